program_loader: RTL and testbench

Boot and run sequencer for the `computer` core. It streams a program into the core's program memory over a valid/ready channel, pads the remaining words with `HALT_INST`, and releases the core from reset. It then counts execution cycles until the core reports halt or a timeout expires. It sits between a host/test source and the `computer` top, and owns the core's reset and the program-memory write port.

---
 rtl/program_loader_pkg.sv | 32 +++
 rtl/program_loader_if.sv | 24 ++
 rtl/program_loader_saturating_counter.sv | 29 ++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the computer core and its program loader.
// Instruction encodings, memory geometry and loader FSM states.
package program_loader_pkg;

  localparam int INST_WIDTH       = 16;
  localparam int PROG_MEMORY_SIZE = 16;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADC = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_ADDF  = 4'h4;
  localparam logic [3:0] OP_SUBF  = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [INST_WIDTH-1:0] HALT_INST = {OP_HALT, 12'h000};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic [INST_WIDTH-1:0] make_inst(
    input logic [3:0] op,
    input logic [3:0] rd,
    input logic [7:0] imm
  );
    return {op, rd, imm};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready program-word channel into the loader.
// master: host source; slave: program_loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int W = INST_WIDTH
) ();

  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         load_last;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready
  );

endinterface

// File: rtl/program_loader_saturating_counter.sv
// Up-counter that sticks at LIMIT instead of wrapping.
// Ports: clk, rst_n, clear, enable -> count, at_limit.
module saturating_counter #(
  parameter int WIDTH = 32,
  parameter int LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  assign at_limit = (count == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot/run sequencer: streams a program into core memory, pads with HALT,
// releases core reset and times the run. Ports: clock, reset (async low),
// start, load channel, mem write port, core_reset/core_halted, status.
module program_loader #(
  parameter int DEPTH      = program_loader_pkg::PROG_MEMORY_SIZE,
  parameter int INST_WIDTH = program_loader_pkg::INST_WIDTH,
  parameter int MAX_CYCLES = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  program_loader_if.slave       load,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [INST_WIDTH-1:0] mem_data,
  output logic                  core_reset,
  input  logic                  core_halted,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [31:0]           cycle_count
);

  import program_loader_pkg::*;

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_END  = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic          go;
  logic          accept;
  logic          fill_wr;
  logic          to_run;
  logic          halt_run;
  logic          expire;
  logic          at_limit;
  logic          cnt_en;

  assign go       = start && (state == S_IDLE || state == S_DONE);
  assign accept   = (state == S_LOAD) && load.load_valid && load.load_ready;
  assign fill_wr  = (state == S_FILL) && (ptr != PTR_END);
  // FILL with nothing left to write is the one idle cycle that lets
  // the final memory write retire before the core leaves reset.
  assign to_run   = (state == S_FILL) && (ptr == PTR_END);
  assign halt_run = (state == S_RUN) && core_halted;
  assign expire   = (state == S_RUN) && !core_halted && at_limit;

  always_comb begin
    state_n = state;
    unique case (1'b1)
      go:       state_n = S_LOAD;
      accept && (load.load_last || ptr == PTR_LAST):
                state_n = S_FILL;
      to_run:   state_n = S_RUN;
      halt_run || expire:
                state_n = S_DONE;
      default:  state_n = state;
    endcase
  end

  always_comb begin
    ptr_n = ptr;
    if (go) begin
      ptr_n = '0;
    end else if (accept || fill_wr) begin
      ptr_n = ptr + PW'(1);
    end
  end

  // Count the entry edge too, so the first RUN cycle reads 1.
  assign cnt_en = to_run || ((state == S_RUN) && (state_n == S_RUN));

  saturating_counter #(
    .WIDTH (32),
    .LIMIT (MAX_CYCLES)
  ) u_cycles (
    .clk      (clock),
    .rst_n    (reset),
    .clear    (go),
    .enable   (cnt_en),
    .count    (cycle_count),
    .at_limit (at_limit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      ptr             <= '0;
      load.load_ready <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_data        <= '0;
      core_reset      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state           <= state_n;
      ptr             <= ptr_n;
      load.load_ready <= (state_n == S_LOAD) && (ptr_n < PTR_END);
      mem_write       <= accept || fill_wr;
      core_reset      <= (state_n == S_RUN) || (state_n == S_DONE);
      busy            <= (state_n == S_LOAD) || (state_n == S_FILL)
                      || (state_n == S_RUN);
      done            <= (state_n == S_DONE);
      if (accept) begin
        mem_address <= ptr[ADDR_WIDTH-1:0];
        mem_data    <= load.load_data;
      end else if (fill_wr) begin
        mem_address <= ptr[ADDR_WIDTH-1:0];
        mem_data    <= INST_WIDTH'(HALT_INST);
      end
      if (go) begin
        timeout <= 1'b0;
      end else if (expire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader.
// Directed loads, halt/timeout runs, async reset and start filtering.
module tb_program_loader;

  import program_loader_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int MAXC  = 50;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  core_halted = 1'b0;
  logic                  mem_write;
  logic [AW-1:0]         mem_address;
  logic [INST_WIDTH-1:0] mem_data;
  logic                  core_reset;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [31:0]           cycle_count;

  program_loader_if #(.W(INST_WIDTH)) load ();

  program_loader #(
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .load        (load),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .core_reset  (core_reset),
    .core_halted (core_halted),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = 0;
  int rise_cyc = 0;
  bit prev_cr = 1'b0;

  int                    exp_a[$];
  logic [INST_WIDTH-1:0] exp_d[$];
  logic [INST_WIDTH-1:0] prog[DEPTH];

  int                    ea;
  logic [INST_WIDTH-1:0] ed;

  always @(posedge clock) cyc <= cyc + 1;

  // Model: the ordered list of (address, data) writes the spec demands,
  // plus run length measured from the core_reset rise.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_write) begin
        wr_count++;
        last_wr_cyc = cyc;
        checks++;
        if (exp_a.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h",
                   mem_address, mem_data);
        end else begin
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          if (mem_address !== AW'(ea) || mem_data !== ed) begin
            failures++;
            $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                     mem_address, mem_data, ea, ed);
          end
        end
        checks++;
        if (core_reset) begin
          failures++;
          $display("FAIL write_in_run core_reset=%b expected 0", core_reset);
        end
      end
      if (core_reset && !prev_cr) rise_cyc = cyc;
      prev_cr = core_reset;
      if (core_reset && !done) begin
        checks++;
        if (cycle_count !== 32'(cyc - rise_cyc + 1)) begin
          failures++;
          $display("FAIL run_count actual=%0d expected=%0d",
                   cycle_count, cyc - rise_cyc + 1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_prog(input int n, input bit fill);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(prog[i]);
    end
    if (fill) begin
      for (int i = n; i < DEPTH; i++) begin
        exp_a.push_back(i);
        exp_d.push_back(HALT_INST);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit use_last, input bit gap);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    while (i < n && guard < 200) begin
      load.load_valid = 1'b1;
      load.load_data  = prog[i];
      load.load_last  = use_last && (i == n - 1);
      @(negedge clock);
      rdy = load.load_ready;
      @(posedge clock); #1;
      guard++;
      if (rdy) begin
        i++;
        if (gap) begin
          load.load_valid = 1'b0;
          load.load_last  = 1'b0;
          @(posedge clock); #1;
        end
      end
    end
    load.load_valid = 1'b0;
    load.load_last  = 1'b0;
    check("load_accepts", 32'(i), 32'(n));
  endtask

  task automatic wait_rise();
    int k = 0;
    while (k < 100) begin
      @(negedge clock); #1;
      if (core_reset) break;
      k++;
    end
    check("core_reset_rise", 32'(core_reset), 32'd1);
    check("rise_after_last_write", 32'(rise_cyc), 32'(last_wr_cyc + 1));
  endtask

  // Called in RUN cycle 1; holds core_halted during RUN cycle k.
  task automatic halt_at(input int k);
    repeat (k - 1) @(posedge clock);
    #1 core_halted = 1'b1;
    @(posedge clock);
    #1 core_halted = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
    check({tag, "_load_ready"}, 32'(load.load_ready), 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    load.load_valid = 1'b0;
    load.load_last  = 1'b0;
    load.load_data  = '0;
    for (int i = 0; i < 8; i++)
      prog[i] = make_inst(OP_LOADC, 4'(i), 8'(i * 3 + 1));
    prog[8]  = make_inst(OP_ADD,  4'd1, 8'h23);
    prog[9]  = make_inst(OP_SUB,  4'd2, 8'h45);
    prog[10] = make_inst(OP_ADDF, 4'd3, 8'h67);
    prog[11] = make_inst(OP_SUBF, 4'd4, 8'h01);
    prog[12] = make_inst(OP_NOP,  4'd0, 8'h00);
    prog[13] = make_inst(OP_NOP,  4'd0, 8'h00);
    prog[14] = make_inst(OP_ADD,  4'd5, 8'h9A);
    prog[15] = make_inst(OP_SUB,  4'd6, 8'hBC);

    #12;
    check_idle_outputs("reset");
    check("literal_loadc0", 32'(prog[0]), 32'h1001);
    check("literal_halt", 32'(HALT_INST), 32'hF000);
    @(negedge clock) reset = 1'b1;

    // 14 words with last, halt in RUN cycle 20
    wr_count = 0;
    expect_prog(14, 1'b1);
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(load.load_ready), 32'd1);
    load_prog(14, 1'b1, 1'b0);
    wait_rise();
    check("t1_writes", 32'(wr_count), 32'd16);
    check("t1_queue", 32'(exp_a.size()), 32'd0);
    halt_at(20);
    check("t1_done", 32'(done), 32'd1);
    check("t1_count", cycle_count, 32'd20);
    check("t1_timeout", 32'(timeout), 32'd0);
    check("t1_core_reset", 32'(core_reset), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // restart from DONE, gapped valid, start ignored in RUN
    wr_count = 0;
    expect_prog(14, 1'b1);
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_timeout_clr", 32'(timeout), 32'd0);
    check("t2_count_clr", cycle_count, 32'd0);
    check("t2_core_reset", 32'(core_reset), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    load_prog(14, 1'b1, 1'b1);
    wait_rise();
    check("t2_writes", 32'(wr_count), 32'd16);
    check("t2_queue", 32'(exp_a.size()), 32'd0);
    pulse_start();
    check("t2_run_done", 32'(done), 32'd0);
    check("t2_run_core_reset", 32'(core_reset), 32'd1);
    check("t2_run_busy", 32'(busy), 32'd1);
    halt_at(5);
    check("t2_done", 32'(done), 32'd1);
    check("t2_count", cycle_count, 32'd7);

    // full 16 words, no last, then timeout
    wr_count = 0;
    expect_prog(16, 1'b0);
    pulse_start();
    load_prog(16, 1'b0, 1'b0);
    check("t3_ready_off", 32'(load.load_ready), 32'd0);
    load.load_valid = 1'b1;
    load.load_data  = prog[0];
    repeat (3) @(posedge clock);
    #1 load.load_valid = 1'b0;
    check("t3_core_reset", 32'(core_reset), 32'd1);
    check("t3_rise", 32'(rise_cyc), 32'(last_wr_cyc + 1));
    check("t3_writes", 32'(wr_count), 32'd16);
    check("t3_queue", 32'(exp_a.size()), 32'd0);
    k = 0;
    while (k < 200) begin
      @(negedge clock); #1;
      if (done) break;
      k++;
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_run_len", 32'(cyc - rise_cyc), 32'd50);
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_count", cycle_count, 32'd50);

    // async reset after 5 words, then reload from address 0
    wr_count = 0;
    expect_prog(5, 1'b0);
    pulse_start();
    load_prog(5, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check("t4_writes", 32'(wr_count), 32'd5);
    check("t4_queue", 32'(exp_a.size()), 32'd0);
    @(negedge clock) reset = 1'b1;
    wr_count = 0;
    expect_prog(14, 1'b1);
    pulse_start();
    load_prog(14, 1'b1, 1'b0);
    wait_rise();
    check("t4_rewrites", 32'(wr_count), 32'd16);
    halt_at(3);
    check("t4_done", 32'(done), 32'd1);
    check("t4_count", cycle_count, 32'd3);
    check("t4_timeout", 32'(timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
